// File: rtl/spi_readback_checker.sv
// -----------------------------------------------------------------------------
// spi_readback_checker
//
// Purpose:
//   Captures serial readback frames returned on MISO (framed by SEL, clocked
//   by the bridge's gated serial clock), classifies each frame by its bit
//   count as dynamic (SIZESRDYN bits) or static (SIZESRSTAT bits), and
//   compares the captured word against the expected configuration. The
//   whole block runs in the CLK domain and oversamples the serial clock.
//
// Optional feature:
//   READBACK_ERRCNT_EN - when defined, adds err_count[7:0], a saturating
//   count of mismatches and length errors seen in CHECK.
//
// Ports:
//   CLK            in   system clock (16 MHz)
//   RST            in   asynchronous active-high reset
//   sclk_in        in   gated serial clock from the bridge (<= CLK/8)
//   sel_in         in   frame select, high while a frame is active
//   miso_in        in   serial data, MSB first
//   expected_dyn   in   expected dynamic configuration word
//   expected_stat  in   expected static configuration word
//   dyn_word       out  last captured dynamic word
//   stat_word      out  last captured static word
//   dyn_ok         out  last dynamic frame matched
//   stat_ok        out  last static frame matched
//   len_err        out  sticky: a frame had an unsupported length
//   frame_done     out  one-CLK pulse per completed frame
//   busy           out  high in SHIFT or CHECK
//   err_count      out  (READBACK_ERRCNT_EN only) saturating error count
// -----------------------------------------------------------------------------
module spi_readback_checker #(
    parameter int SIZESRSTAT  = 88,
    parameter int SIZESRDYN   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sclk_in,
    input  logic                  sel_in,
    input  logic                  miso_in,
    input  logic [SIZESRDYN-1:0]  expected_dyn,
    input  logic [SIZESRSTAT-1:0] expected_stat,
    output logic [SIZESRDYN-1:0]  dyn_word,
    output logic [SIZESRSTAT-1:0] stat_word,
    output logic                  dyn_ok,
    output logic                  stat_ok,
    output logic                  len_err,
    output logic                  frame_done,
    output logic                  busy
`ifdef READBACK_ERRCNT_EN
    ,
    output logic [7:0]            err_count
`endif
);

    localparam logic [6:0] DYN_LEN  = 7'(SIZESRDYN);
    localparam logic [6:0] STAT_LEN = 7'(SIZESRSTAT);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- input synchronizers ----------------
    logic [SYNC_STAGES-1:0] sclk_sync_q, sel_sync_q, miso_sync_q, sync_vld_q;
    logic                   sclk_dly_q, sel_dly_q, armed_q;
    logic                   sclk_s, sel_s, miso_s;
    logic                   sclk_rise, sel_rise, sel_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign sel_s  = sel_sync_q[SYNC_STAGES-1];
    assign miso_s = miso_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= '0;
            sel_sync_q  <= '0;
            miso_sync_q <= '0;
            sync_vld_q  <= '0;
            sclk_dly_q  <= 1'b0;
            sel_dly_q   <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            sel_sync_q  <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
            miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], miso_in};
            sync_vld_q  <= {sync_vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_dly_q  <= sclk_s;
            sel_dly_q   <= sel_s;
            // Only arm once a genuinely low sel has propagated through the
            // refilled synchronizer, so a frame in flight at reset release
            // is ignored until it ends.
            if (sync_vld_q[SYNC_STAGES-1] && !sel_s)
                armed_q <= 1'b1;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sel_rise  = armed_q & sel_s & ~sel_dly_q;
    assign sel_fall  = sel_dly_q & ~sel_s;

    // ---------------- FSM ----------------
    state_t state_q, state_d;
    logic   start_c, shift_c, check_c, done_c, busy_c;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_rise) state_d = SHIFT;
            SHIFT:   if (sel_fall) state_d = CHECK;
            CHECK:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_c = (state_q == IDLE) && sel_rise;
        // A bit arriving in the same cycle as sel falling is still taken.
        shift_c = (state_q == SHIFT) && sclk_rise;
        check_c = (state_q == CHECK);
        done_c  = (state_q == DONE);
        busy_c  = (state_q == SHIFT) || (state_q == CHECK);
    end

    assign busy = busy_c;

    // ---------------- capture datapath ----------------
    logic [SIZESRSTAT-1:0] sr_q;
    logic [6:0]            count_q;
    logic [SIZESRDYN-1:0]  dyn_word_q;
    logic [SIZESRSTAT-1:0] stat_word_q;
    logic                  dyn_ok_q, stat_ok_q, len_err_q, frame_done_q;
    logic                  dyn_match, stat_match, check_err;

    assign dyn_match  = (sr_q[SIZESRDYN-1:0] == expected_dyn);
    assign stat_match = (sr_q == expected_stat);
    assign check_err  = (count_q == DYN_LEN)  ? !dyn_match  :
                        (count_q == STAT_LEN) ? !stat_match : 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr_q         <= '0;
            count_q      <= '0;
            dyn_word_q   <= '0;
            stat_word_q  <= '0;
            dyn_ok_q     <= 1'b0;
            stat_ok_q    <= 1'b0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= done_c;
            if (start_c) begin
                sr_q    <= '0;
                count_q <= '0;
            end else if (shift_c) begin
                sr_q    <= {sr_q[SIZESRSTAT-2:0], miso_s};
                count_q <= sat_inc7(count_q);
            end
            if (check_c) begin
                if (count_q == DYN_LEN) begin
                    dyn_word_q <= sr_q[SIZESRDYN-1:0];
                    dyn_ok_q   <= dyn_match;
                end else if (count_q == STAT_LEN) begin
                    stat_word_q <= sr_q;
                    stat_ok_q   <= stat_match;
                end else begin
                    len_err_q <= 1'b1;
                end
            end
        end
    end

    assign dyn_word   = dyn_word_q;
    assign stat_word  = stat_word_q;
    assign dyn_ok     = dyn_ok_q;
    assign stat_ok    = stat_ok_q;
    assign len_err    = len_err_q;
    assign frame_done = frame_done_q;

`ifdef READBACK_ERRCNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                        err_count_q <= '0;
        else if (check_c && check_err)  err_count_q <= sat_inc8(err_count_q);
    end

    assign err_count = err_count_q;
`else
    logic unused_err;
    assign unused_err = check_err;
`endif

endmodule

// File: tb/tb_spi_readback_checker.sv
`timescale 1ns/1ps
module tb_spi_readback_checker;

    localparam int SYNC_STAGES = 2;
    localparam int LAT = SYNC_STAGES + 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        sclk_in = 1'b0;
    logic        sel_in = 1'b0;
    logic        miso_in = 1'b0;
    logic [15:0] expected_dyn = '0;
    logic [87:0] expected_stat = '0;
    logic [15:0] dyn_word;
    logic [87:0] stat_word;
    logic        dyn_ok, stat_ok, len_err, frame_done, busy;
`ifdef READBACK_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    int checks = 0;
    int errors = 0;

    spi_readback_checker #(
        .SIZESRSTAT (88),
        .SIZESRDYN  (16),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .sclk_in      (sclk_in),
        .sel_in       (sel_in),
        .miso_in      (miso_in),
        .expected_dyn (expected_dyn),
        .expected_stat(expected_stat),
        .dyn_word     (dyn_word),
        .stat_word    (stat_word),
        .dyn_ok       (dyn_ok),
        .stat_ok      (stat_ok),
        .len_err      (len_err),
        .frame_done   (frame_done),
        .busy         (busy)
`ifdef READBACK_ERRCNT_EN
        ,
        .err_count    (err_count)
`endif
    );

    always #31.25 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic sel_start(input int div);
        @(negedge CLK);
        sclk_in = 1'b0;
        sel_in  = 1'b1;
        idle(div);
    endtask

    task automatic send_bits(input logic [127:0] data, input int hi, input int lo, input int div);
        for (int i = hi; i >= lo; i--) begin
            miso_in = data[i];
            sclk_in = 1'b0;
            idle(div / 2);
            sclk_in = 1'b1;
            idle(div / 2);
        end
    endtask

    task automatic sel_end(input int div);
        sclk_in = 1'b0;
        idle(div / 2);
        sel_in = 1'b0;
    endtask

    // Called right after sel_in is driven low at a falling edge: the next
    // rising edge is the first to sample it low.
    task automatic wait_done(input string tag, input int exp_lat);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        @(posedge CLK);
        while (n < 30 && !seen) begin
            @(posedge CLK);
            n++;
            #1;
            if (frame_done) seen = 1'b1;
        end
        chk({tag, "_lat"}, n, exp_lat);
        @(posedge CLK);
        #1;
        chk({tag, "_pulse"}, frame_done, 1'b0);
    endtask

    task automatic send_frame(input string tag, input logic [127:0] data, input int nbits, input int div);
        sel_start(div);
        send_bits(data, nbits - 1, 0, div);
        sel_end(div);
        wait_done(tag, LAT);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_dyn_word"},   dyn_word,   '0);
        chk({tag, "_stat_word"},  stat_word,  '0);
        chk({tag, "_dyn_ok"},     dyn_ok,     1'b0);
        chk({tag, "_stat_ok"},    stat_ok,    1'b0);
        chk({tag, "_len_err"},    len_err,    1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_busy"},       busy,       1'b0);
`ifdef READBACK_ERRCNT_EN
        chk({tag, "_err_count"},  err_count,  '0);
`endif
    endtask

    task automatic check_errcnt(input string tag, input int exp);
`ifdef READBACK_ERRCNT_EN
        chk({tag, "_err_count"}, err_count, exp);
`else
        if (exp < 0) $display("%s unused", tag);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;

        // Reset state
        RST = 1'b1;
        idle(3);
        #1;
        check_zero("rst");
        @(negedge CLK);
        RST = 1'b0;
        idle(6);

        // 1. Dynamic match
        expected_dyn = 16'h4321;
        sel_start(8);
        chk("t1_busy", busy, 1'b1);
        send_bits(128'h4321, 15, 0, 8);
        sel_end(8);
        wait_done("t1", LAT);
        chk("t1_dyn_word", dyn_word, 16'h4321);
        chk("t1_dyn_ok",   dyn_ok,   1'b1);
        chk("t1_len_err",  len_err,  1'b0);
        chk("t1_stat_ok",  stat_ok,  1'b0);
        chk("t1_busy_end", busy,     1'b0);

        // 2. Static mismatch (bit 0 flipped)
        expected_stat = 88'hFEDCBA9876543210012345;
        send_frame("t2", 128'hFEDCBA9876543210012344, 88, 8);
        chk("t2_stat_word", stat_word, 88'hFEDCBA9876543210012344);
        chk("t2_stat_ok",   stat_ok,   1'b0);
        chk("t2_dyn_ok",    dyn_ok,    1'b1);
        chk("t2_len_err",   len_err,   1'b0);
        check_errcnt("t2", 1);

        // 3. Bad length, then dynamic mismatch and match
        send_frame("t3a", 128'h1ABCD, 17, 8);
        chk("t3a_len_err",   len_err,   1'b1);
        chk("t3a_dyn_ok",    dyn_ok,    1'b1);
        chk("t3a_dyn_word",  dyn_word,  16'h4321);
        chk("t3a_stat_ok",   stat_ok,   1'b0);
        chk("t3a_stat_word", stat_word, 88'hFEDCBA9876543210012344);
        check_errcnt("t3a", 2);
        expected_dyn = 16'h5A5A;
        send_frame("t3b", 128'h5A5B, 16, 8);
        chk("t3b_dyn_word", dyn_word, 16'h5A5B);
        chk("t3b_dyn_ok",   dyn_ok,   1'b0);
        check_errcnt("t3b", 3);
        send_frame("t3c", 128'h5A5A, 16, 8);
        chk("t3c_dyn_word", dyn_word, 16'h5A5A);
        chk("t3c_dyn_ok",   dyn_ok,   1'b1);
        chk("t3c_len_err",  len_err,  1'b1);
        check_errcnt("t3c", 3);

        // 4. Back-to-back dynamic (CLK/8) then static (CLK/16)
        expected_dyn  = 16'hABCD;
        expected_stat = 88'h123456789ABCDEF1234567;
        send_frame("t4a", 128'hABCD, 16, 8);
        idle(10);
        send_frame("t4b", 128'h123456789ABCDEF1234567, 88, 16);
        chk("t4_dyn_word",  dyn_word,  16'hABCD);
        chk("t4_dyn_ok",    dyn_ok,    1'b1);
        chk("t4_stat_word", stat_word, 88'h123456789ABCDEF1234567);
        chk("t4_stat_ok",   stat_ok,   1'b1);
        check_errcnt("t4", 3);

        // 5. Reset mid-frame
        sel_start(8);
        send_bits(128'hABCD, 15, 8, 8);
        RST = 1'b1;
        #1;
        check_zero("t5_rst");
        idle(2);
        RST = 1'b0;
        send_bits(128'hABCD, 7, 0, 8);
        sel_end(8);
        hits = 0;
        repeat (30) begin
            @(posedge CLK);
            #1;
            if (frame_done) hits++;
        end
        chk("t5_no_done", hits, 0);
        chk("t5_busy", busy, 1'b0);
        send_frame("t5b", 128'hABCD, 16, 8);
        chk("t5b_dyn_word", dyn_word, 16'hABCD);
        chk("t5b_dyn_ok",   dyn_ok,   1'b1);
        chk("t5b_len_err",  len_err,  1'b0);
        chk("t5b_stat_ok",  stat_ok,  1'b0);

        // Zero-length frame: sel pulse without serial clocks
        sel_start(8);
        idle(8);
        sel_in = 1'b0;
        wait_done("zl", LAT);
        chk("zl_len_err",  len_err,  1'b1);
        chk("zl_dyn_ok",   dyn_ok,   1'b1);
        chk("zl_dyn_word", dyn_word, 16'hABCD);
        check_errcnt("zl", 1);

        // 6. Last sclk rise coincident with sel fall
        expected_dyn = 16'h8001;
        sel_start(8);
        send_bits(128'h8001, 15, 1, 8);
        miso_in = 1'b1;
        sclk_in = 1'b0;
        idle(4);
        sclk_in = 1'b1;
        sel_in  = 1'b0;
        wait_done("t6", LAT);
        @(negedge CLK);
        sclk_in = 1'b0;
        chk("t6_dyn_word", dyn_word, 16'h8001);
        chk("t6_dyn_ok",   dyn_ok,   1'b1);
        chk("t6_len_err",  len_err,  1'b1);
        check_errcnt("t6", 1);

        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
